// File: rtl/puf_eval_ctrl.sv
// Evaluation controller for a 4-bit ring-oscillator PUF array.
// Runs one challenge NUM_EVAL times, counts ones per response bit and returns a
// majority-voted response together with a per-bit instability mask.

module puf_eval_ctrl #(
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned EVAL_CYCLES   = 64,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_EVAL      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_cha0,
  input  logic [3:0] req_cha1,
  output logic       puf_reset,
  output logic [3:0] puf_cha0,
  output logic [3:0] puf_cha1,
  output logic       puf_enable,
  input  logic [3:0] puf_response,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [3:0] resp_data,
  output logic [3:0] resp_unstable,
  output logic       busy
);

  localparam int unsigned CntW   = $clog2(NUM_EVAL + 1);
  localparam int unsigned IdxW   = (NUM_EVAL > 1) ? $clog2(NUM_EVAL) : 1;
  localparam int unsigned MaxCyc =
      (RST_CYCLES > EVAL_CYCLES) ?
      ((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES) :
      ((EVAL_CYCLES > SETTLE_CYCLES) ? EVAL_CYCLES : SETTLE_CYCLES);
  localparam int unsigned CycW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StRun,
    StSettle,
    StSample,
    StVote,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q [4];
  logic [CntW-1:0]   cnt_d [4];
  logic [3:0]        cha0_q, cha0_d;
  logic [3:0]        cha1_q, cha1_d;
  logic [3:0]        data_q, data_d;
  logic [3:0]        unst_q, unst_d;

  logic              req_ready_q;
  logic              puf_reset_q;
  logic              puf_enable_q;
  logic              resp_valid_q;
  logic              busy_q;

  // Next-state and datapath update for the evaluation sequence.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cha0_d  = cha0_q;
    cha1_d  = cha1_q;
    data_d  = data_q;
    unst_d  = unst_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          cha0_d = req_cha0;
          cha1_d = req_cha1;
          for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
          end
          idx_d   = '0;
          cyc_d   = '0;
          state_d = StClr;
        end
      end

      StClr: begin
        if (cyc_q == CycW'(RST_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = StRun;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      StRun: begin
        if (cyc_q == CycW'(EVAL_CYCLES - 1)) begin
          cyc_d   = '0;
          // With no settle time the response is sampled straight after the run.
          state_d = (SETTLE_CYCLES == 0) ? StSample : StSettle;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      StSettle: begin
        if (cyc_q == CycW'(SETTLE_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = StSample;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      StSample: begin
        for (int i = 0; i < 4; i++) begin
          cnt_d[i] = cnt_q[i] + CntW'(puf_response[i]);
        end
        if (idx_q == IdxW'(NUM_EVAL - 1)) begin
          state_d = StVote;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StClr;
        end
      end

      StVote: begin
        // NUM_EVAL is odd, so a strict majority always exists.
        for (int i = 0; i < 4; i++) begin
          data_d[i] = (cnt_q[i] > CntW'(NUM_EVAL / 2));
          unst_d[i] = (cnt_q[i] != '0) && (cnt_q[i] != CntW'(NUM_EVAL));
        end
        state_d = StDone;
      end

      StDone: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      cha0_q  <= '0;
      cha1_q  <= '0;
      data_q  <= '0;
      unst_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cha0_q  <= cha0_d;
      cha1_q  <= cha1_d;
      data_q  <= data_d;
      unst_q  <= unst_d;
    end
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready_q  <= 1'b1;
      puf_reset_q  <= 1'b1;
      puf_enable_q <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      req_ready_q  <= (state_d == StIdle);
      puf_reset_q  <= (state_d == StIdle) || (state_d == StClr) || (state_d == StDone);
      puf_enable_q <= (state_d == StRun);
      resp_valid_q <= (state_d == StDone);
      busy_q       <= (state_d != StIdle);
    end
  end

  assign req_ready     = req_ready_q;
  assign puf_reset     = puf_reset_q;
  assign puf_enable    = puf_enable_q;
  assign puf_cha0      = cha0_q;
  assign puf_cha1      = cha1_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = data_q;
  assign resp_unstable = unst_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: a default-parameter instance and a
// short single-evaluation instance, driven by a simple PUF model.

module tb_puf_eval_ctrl;

  logic       clk;
  logic       rst_n;

  logic       req_valid     [2];
  logic       req_ready     [2];
  logic [3:0] req_cha0      [2];
  logic [3:0] req_cha1      [2];
  logic       puf_reset     [2];
  logic [3:0] puf_cha0      [2];
  logic [3:0] puf_cha1      [2];
  logic       puf_enable    [2];
  logic [3:0] puf_response  [2];
  logic       resp_valid    [2];
  logic       resp_ready    [2];
  logic [3:0] resp_data     [2];
  logic [3:0] resp_unstable [2];
  logic       busy          [2];

  // Per-evaluation PUF responses for the current transaction.
  logic [3:0] seq [16];

  int n_checks;
  int n_errors;

  puf_eval_ctrl u_dut_a (
    .clk          (clk),
    .reset        (rst_n),
    .req_valid    (req_valid[0]),
    .req_ready    (req_ready[0]),
    .req_cha0     (req_cha0[0]),
    .req_cha1     (req_cha1[0]),
    .puf_reset    (puf_reset[0]),
    .puf_cha0     (puf_cha0[0]),
    .puf_cha1     (puf_cha1[0]),
    .puf_enable   (puf_enable[0]),
    .puf_response (puf_response[0]),
    .resp_valid   (resp_valid[0]),
    .resp_ready   (resp_ready[0]),
    .resp_data    (resp_data[0]),
    .resp_unstable(resp_unstable[0]),
    .busy         (busy[0])
  );

  puf_eval_ctrl #(
    .RST_CYCLES   (2),
    .EVAL_CYCLES  (4),
    .SETTLE_CYCLES(0),
    .NUM_EVAL     (1)
  ) u_dut_b (
    .clk          (clk),
    .reset        (rst_n),
    .req_valid    (req_valid[1]),
    .req_ready    (req_ready[1]),
    .req_cha0     (req_cha0[1]),
    .req_cha1     (req_cha1[1]),
    .puf_reset    (puf_reset[1]),
    .puf_cha0     (puf_cha0[1]),
    .puf_cha1     (puf_cha1[1]),
    .puf_enable   (puf_enable[1]),
    .puf_response (puf_response[1]),
    .resp_valid   (resp_valid[1]),
    .resp_ready   (resp_ready[1]),
    .resp_data    (resp_data[1]),
    .resp_unstable(resp_unstable[1]),
    .busy         (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Configuration of each instance as the bench knows it.
  function automatic int cfg_ne(input int s);
    return (s == 0) ? 5 : 1;
  endfunction
  function automatic int cfg_rc(input int s);
    return 2;
  endfunction
  function automatic int cfg_ec(input int s);
    return (s == 0) ? 64 : 4;
  endfunction
  function automatic int cfg_sc(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input int s, input string tag);
    check({tag, "_ready"},  32'(req_ready[s]),  32'd1);
    check({tag, "_pufrst"}, 32'(puf_reset[s]),  32'd1);
    check({tag, "_enable"}, 32'(puf_enable[s]), 32'd0);
    check({tag, "_cha"},    32'({puf_cha0[s], puf_cha1[s]}), 32'h0);
    check({tag, "_rvalid"}, 32'(resp_valid[s]), 32'd0);
    check({tag, "_resp"},   32'({resp_data[s], resp_unstable[s]}), 32'h0);
    check({tag, "_busy"},   32'(busy[s]),       32'd0);
  endtask

  // One request on instance s using seq[]; called at a negedge with the DUT idle.
  // With hold > 0 the result is backpressured and a second request is left in flight.
  task automatic run_txn(input int s, input logic [3:0] c0, input logic [3:0] c1,
                         input int hold, input string tag);
    int         ne;
    int         cnt [4];
    logic [3:0] exp_d;
    logic [3:0] exp_u;
    int         lat;
    int         pulses;
    int         en_cyc;
    int         rst_cyc;
    int         idx;
    int         cha_bad;
    int         hold_bad;
    logic       en_prev;

    ne = cfg_ne(s);
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      for (int e = 0; e < ne; e++) cnt[i] += int'(seq[e][i]);
      exp_d[i] = (cnt[i] > ne / 2);
      exp_u[i] = (cnt[i] != 0) && (cnt[i] != ne);
    end

    req_cha0[s]  = c0;
    req_cha1[s]  = c1;
    req_valid[s] = 1'b1;
    check({tag, "_ready_idle"}, 32'(req_ready[s]), 32'd1);
    @(negedge clk);
    req_valid[s] = 1'b0;
    req_cha0[s]  = $urandom;
    req_cha1[s]  = $urandom;

    lat = -1; pulses = 0; en_cyc = 0; rst_cyc = 0; idx = 0; cha_bad = 0; en_prev = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        check({tag, "_busy_acc"}, 32'(busy[s]), 32'd1);
        check({tag, "_ready_acc"}, 32'(req_ready[s]), 32'd0);
      end
      if (resp_valid[s]) begin
        lat = k;
        break;
      end
      if (puf_cha0[s] !== c0 || puf_cha1[s] !== c1) cha_bad++;
      // The PUF model presents the next evaluation's response as Enable rises.
      if (puf_enable[s] && !en_prev) begin
        pulses++;
        if (idx < 16) puf_response[s] = seq[idx];
        idx++;
      end
      en_prev = puf_enable[s];
      if (puf_enable[s]) en_cyc++;
      if (puf_reset[s]) rst_cyc++;
    end

    check({tag, "_latency"}, 32'(lat),
          32'(ne * (cfg_rc(s) + cfg_ec(s) + cfg_sc(s) + 1) + 1));
    check({tag, "_pulses"},  32'(pulses),  32'(ne));
    check({tag, "_en_cyc"},  32'(en_cyc),  32'(ne * cfg_ec(s)));
    check({tag, "_rst_cyc"}, 32'(rst_cyc), 32'(ne * cfg_rc(s)));
    check({tag, "_cha"},     32'(cha_bad), 32'd0);
    check({tag, "_data"},    32'(resp_data[s]), 32'(exp_d));
    check({tag, "_unst"},    32'(resp_unstable[s]), 32'(exp_u));
    check({tag, "_done_ctl"}, 32'({puf_reset[s], puf_enable[s], busy[s], req_ready[s]}),
          32'b1010);

    hold_bad = 0;
    if (hold > 0) begin
      req_cha0[s]  = ~c0;
      req_cha1[s]  = ~c1;
      req_valid[s] = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (resp_valid[s] !== 1'b1 || req_ready[s] !== 1'b0 || resp_data[s] !== exp_d ||
            resp_unstable[s] !== exp_u || puf_cha0[s] !== c0 || puf_cha1[s] !== c1)
          hold_bad++;
      end
      check({tag, "_hold"}, 32'(hold_bad), 32'd0);
    end

    resp_ready[s] = 1'b1;
    @(negedge clk);
    resp_ready[s] = 1'b0;
    check({tag, "_rv_drop"}, 32'(resp_valid[s]), 32'd0);
    check({tag, "_rdy_back"}, 32'(req_ready[s]), 32'd1);
    check({tag, "_retain"}, 32'({resp_data[s], resp_unstable[s], puf_cha0[s], puf_cha1[s]}),
          32'({exp_d, exp_u, c0, c1}));

    if (hold > 0) begin
      @(negedge clk);
      req_valid[s] = 1'b0;
      check({tag, "_b2b_acc"}, 32'({busy[s], puf_cha0[s], puf_cha1[s]}), 32'({1'b1, ~c0, ~c1}));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s]    = 1'b1;
      req_cha0[s]     = 4'h5;
      req_cha1[s]     = 4'hA;
      puf_response[s] = 4'h0;
      resp_ready[s]   = 1'b0;
    end
    rst_n = 1'b0;

    // Held in reset with a pending request: nothing must be accepted.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) check_reset_vals(s, "por");
    for (int s = 0; s < 2; s++) req_valid[s] = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset asserted mid-idle.
    for (int s = 0; s < 2; s++) req_valid[s] = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_vals(0, "idle_rst");
    repeat (3) @(negedge clk);
    check("idle_rst_noacc", 32'({busy[0], busy[1]}), 32'd0);
    for (int s = 0; s < 2; s++) req_valid[s] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Stray resp_ready while idle changes nothing.
    resp_ready[0] = 1'b1;
    @(negedge clk);
    resp_ready[0] = 1'b0;
    check("stray_rready", 32'({busy[0], resp_valid[0], req_ready[0]}), 32'b001);

    // Stable response on every evaluation.
    for (int e = 0; e < 16; e++) seq[e] = 4'b1010;
    run_txn(0, 4'h3, 4'hC, 0, "stable");
    check("stable_abs", 32'({resp_data[0], resp_unstable[0]}), 32'({4'b1010, 4'b0000}));

    // Noisy PUF: ones per bit 3/2/5/0, backpressured, then a back-to-back request.
    seq[0] = 4'b0111; seq[1] = 4'b0111; seq[2] = 4'b0101; seq[3] = 4'b0100; seq[4] = 4'b0100;
    run_txn(0, 4'h9, 4'h6, 20, "noisy");
    check("noisy_abs", 32'({resp_data[0], resp_unstable[0]}), 32'({4'b0101, 4'b0011}));

    // Reset in the middle of the in-flight request's RUN phase.
    repeat (100) @(negedge clk);
    check("mid_run_enable", 32'(puf_enable[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals(0, "mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // No stale counts may survive the reset.
    for (int e = 0; e < 16; e++) seq[e] = 4'b1111;
    run_txn(0, 4'h1, 4'h2, 0, "after_rst");

    // Randomized PUF responses.
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 16; e++) seq[e] = 4'($urandom);
      run_txn(0, 4'($urandom), 4'($urandom), 0, "rand_a");
    end

    // Single-evaluation instance.
    seq[0] = 4'b0110;
    run_txn(1, 4'hE, 4'h7, 0, "single");
    for (int r = 0; r < 3; r++) begin
      seq[0] = 4'($urandom);
      run_txn(1, 4'($urandom), 4'($urandom), 0, "rand_b");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
